// File: rtl/sample_capture_ctrl.sv
// Logic-analyser capture sequencer for a 2^AW x DW single-port block RAM.
// While armed, samples are written into the RAM as a ring buffer. A trigger
// starts a programmable post-trigger count. The captured window is then
// streamed out oldest-first over a valid/ready handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for arm, RAM untouched
// S_ARMED    | ring-buffer capture, waiting for run
// S_POST     | capturing post-trigger samples until post_left runs out
// S_RD_ISSUE | read request for rd_ptr presented to the RAM
// S_RD_WAIT  | RAM read latency cycle, mem_dout registered into out_data
// S_RD_HOLD  | out_valid high, waiting for out_ready
module sample_capture_ctrl #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          abort,
    input  logic          run,
    input  logic [AW-1:0] post_count,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          armed,
    output logic          reading,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_HOLD
    } state_t;

    // fill saturates at the full RAM depth, hence one extra bit
    localparam logic [AW:0] DEPTH_FILL = (AW + 1)'(1) << AW;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   fill;
    logic [AW-1:0] post_left;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   rd_left;

    logic          capturing;
    logic          wr_fire;
    logic          cap_end;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW:0]   fill_nxt;
    logic [AW-1:0] rd_start;

    assign capturing = (state == S_ARMED) || (state == S_POST);
    assign armed     = capturing;
    assign reading   = (state == S_RD_ISSUE) || (state == S_RD_WAIT) || (state == S_RD_HOLD);

    // A sample is written only while capturing; abort and reset suppress the write
    assign wr_fire    = capturing && sample_valid && !abort && !reset;
    assign wr_ptr_nxt = wr_fire ? wr_ptr + AW'(1) : wr_ptr;
    assign fill_nxt   = (wr_fire && (fill != DEPTH_FILL)) ? fill + (AW + 1)'(1) : fill;

    // Once the ring has wrapped, the oldest sample sits at the next write slot
    assign rd_start = (fill_nxt == DEPTH_FILL) ? wr_ptr_nxt : '0;

    // Capture finishes on a zero-length trigger or on the last post-trigger write
    assign cap_end = !abort &&
                     (((state == S_ARMED) && run && (post_count == '0)) ||
                      ((state == S_POST) && wr_fire && (post_left == AW'(1))));

    // RAM port: capture writes take the port, otherwise only RD_ISSUE reads
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = wr_ptr;
        mem_din  = sample_data;
        if (wr_fire) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end else if ((state == S_RD_ISSUE) && !abort && !reset) begin
            mem_en   = 1'b1;
            mem_addr = rd_ptr;
        end
    end

    // Sequencer state, pointers, counters and registered readout outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            post_left <= '0;
            rd_ptr    <= '0;
            rd_left   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state  <= S_ARMED;
                            wr_ptr <= '0;
                            fill   <= '0;
                        end
                    end
                    S_ARMED, S_POST: begin
                        wr_ptr <= wr_ptr_nxt;
                        fill   <= fill_nxt;
                        if (state == S_POST && wr_fire) begin
                            post_left <= post_left - AW'(1);
                        end
                        if (cap_end) begin
                            rd_ptr  <= rd_start;
                            rd_left <= fill_nxt;
                            if (fill_nxt == '0) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_RD_ISSUE;
                            end
                        end else if (state == S_ARMED && run) begin
                            state     <= S_POST;
                            post_left <= post_count;
                        end
                    end
                    S_RD_ISSUE: begin
                        state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        out_data  <= mem_dout;
                        out_valid <= 1'b1;
                        state     <= S_RD_HOLD;
                    end
                    S_RD_HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            rd_ptr    <= rd_ptr + AW'(1);
                            rd_left   <= rd_left - (AW + 1)'(1);
                            if (rd_left == (AW + 1)'(1)) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_RD_ISSUE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Self-checking bench for sample_capture_ctrl with a behavioural RAM and a
// sample-history reference model (last DEPTH written samples, oldest first).
module tb_sample_capture_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          run;
    logic [AW-1:0] post_count;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          armed;
    logic          reading;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] hist[$];
    int            nwr;

    logic [DW-1:0] ram [0:DEPTH-1];

    sample_capture_ctrl #(.AW(AW), .DW(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .run          (run),
        .post_count   (post_count),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .armed        (armed),
        .reading      (reading),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 2048 x 8 block RAM with one-cycle read latency
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout      <= ram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        arm          = 1'b0;
        abort        = 1'b0;
        run          = 1'b0;
        sample_valid = 1'b0;
        out_ready    = 1'b0;
    endtask

    // Arms, streams samples, triggers at trig_cycle, optionally aborts after
    // abort_at post-trigger writes. Returns at the negedge after the last capture edge.
    task automatic do_capture(input int trig_cycle, input int post, input int vprob,
                              input int abort_at, input bit seqd, output bit aborted);
        int cyc = 0;
        int post_wr = 0;
        bit trig = 0;
        bit trig_prev;
        bit fin = 0;
        bit sv;
        logic [DW-1:0] d;
        hist.delete();
        nwr = 0;
        aborted = 0;
        @(negedge clock);
        idle_inputs();
        arm = 1'b1;
        post_count = AW'(post);
        @(negedge clock);
        arm = 1'b0;
        check_eq("armed_after_arm", armed, 1);
        while (!fin && cyc < 20000) begin
            sv = ($urandom_range(99) < vprob);
            d = seqd ? DW'(cyc) : DW'($urandom);
            sample_valid = sv;
            sample_data  = d;
            run   = trig ? 1'($urandom_range(1)) : (cyc == trig_cycle);
            abort = trig && (post_wr == abort_at);
            arm   = 1'($urandom_range(1));
            #1;
            check_eq("cap_mem_we", mem_we, sv && !abort);
            if (sv && !abort) begin
                check_eq("cap_addr", mem_addr, nwr % DEPTH);
                check_eq("cap_din", mem_din, d);
            end
            @(posedge clock);
            trig_prev = trig;
            if (abort) begin
                aborted = 1;
                fin = 1;
            end else begin
                if (sv) begin
                    hist.push_back(d);
                    if (hist.size() > DEPTH) void'(hist.pop_front());
                    nwr++;
                end
                if (!trig && run) begin
                    trig = 1;
                    if (post == 0) fin = 1;
                end
                if (trig_prev && sv) post_wr++;
                if (trig_prev && post_wr == post) fin = 1;
            end
            cyc++;
            @(negedge clock);
            idle_inputs();
            if (!fin) check_eq("armed_hold", armed, 1);
        end
        if (!fin) check_eq("capture_timeout", 0, 1);
        if (aborted) begin
            check_eq("abort_armed", armed, 0);
            check_eq("abort_reading", reading, 0);
            check_eq("abort_mem_we", mem_we, 0);
            for (int i = 0; i < 4; i++) begin
                check_eq("abort_out_valid", out_valid, 0);
                check_eq("abort_done", done, 0);
                @(negedge clock);
            end
        end
    endtask

    // Drains the readout, checking order, addresses, spacing and done.
    // bp forces that many not-ready cycles on word 1; reset_at resets mid-hold.
    task automatic do_readout(input int bp, input int reset_at);
        int n = hist.size();
        int start = (nwr >= DEPTH) ? (nwr % DEPTH) : 0;
        int k = 0;
        int gap = 0;
        int cyc = 0;
        int held = 0;
        bit fin = 0;
        bit prev_valid = 0;
        bit acc;
        if (n == 0) begin
            check_eq("empty_done", done, 1);
            check_eq("empty_reading", reading, 0);
            check_eq("empty_out_valid", out_valid, 0);
            @(negedge clock);
            check_eq("empty_done_clr", done, 0);
            return;
        end
        while (!fin && cyc < 40 * n + 100) begin
            gap++;
            cyc++;
            check_eq("rd_reading", reading, 1);
            check_eq("rd_armed", armed, 0);
            check_eq("rd_done_low", done, 0);
            if (reset_at == k && out_valid) begin
                reset = 1'b1;
                out_ready = 1'b1;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                idle_inputs();
                check_eq("rst_armed", armed, 0);
                check_eq("rst_reading", reading, 0);
                check_eq("rst_out_valid", out_valid, 0);
                check_eq("rst_out_data", out_data, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_mem_en", mem_en, 0);
                check_eq("rst_mem_we", mem_we, 0);
                return;
            end
            if (k == 1 && out_valid && held < bp) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = ($urandom_range(99) < 60);
            end
            sample_valid = 1'($urandom_range(1));
            sample_data  = DW'($urandom);
            arm          = 1'($urandom_range(1));
            run          = 1'($urandom_range(1));
            #1;
            check_eq("rd_mem_we", mem_we, 0);
            if (mem_en) check_eq("rd_addr", mem_addr, (start + k) % DEPTH);
            if (out_valid) begin
                check_eq("rd_data", out_data, hist[k]);
                check_eq("rd_hold_no_ram", mem_en, 0);
                if (!prev_valid) check_eq("rd_gap", gap, 3);
            end
            prev_valid = out_valid;
            acc = out_valid && out_ready;
            @(posedge clock);
            if (acc) begin
                k++;
                gap = 0;
            end
            @(negedge clock);
            idle_inputs();
            if (k == n) fin = 1;
        end
        if (!fin) begin
            check_eq("readout_timeout", k, n);
            return;
        end
        check_eq("last_done", done, 1);
        check_eq("last_reading", reading, 0);
        check_eq("last_out_valid", out_valid, 0);
        check_eq("last_armed", armed, 0);
        @(negedge clock);
        check_eq("done_pulse_clr", done, 0);
        check_eq("idle_after_done", reading, 0);
    endtask

    initial begin
        bit ab;
        idle_inputs();
        reset        = 1'b1;
        post_count   = '0;
        sample_data  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_eq("reset_armed", armed, 0);
        check_eq("reset_reading", reading, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", out_data, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_mem_en", mem_en, 0);

        // run while idle is ignored
        run = 1'b1;
        sample_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_eq("idle_run_armed", armed, 0);
            check_eq("idle_run_reading", reading, 0);
            check_eq("idle_mem_we", mem_we, 0);
        end
        idle_inputs();

        // no wrap, trigger on the fifth sample, 5 post samples, backpressure on word 1
        do_capture(4, 5, 100, -1, 1, ab);
        do_readout(5, -1);

        // wrap: 3000 samples, trigger on the last one
        do_capture(2999, 0, 100, -1, 1, ab);
        do_readout(0, -1);

        // abort after 3 of 8 post samples, then a fresh capture from address 0
        do_capture(3, 8, 100, 3, 0, ab);
        check_eq("abort_taken", ab, 1);
        do_capture(2, 3, 70, -1, 0, ab);
        do_readout(2, -1);

        // reset while holding a word, then a two-sample capture
        do_capture(10, 6, 80, -1, 0, ab);
        do_readout(0, 3);
        do_capture(1, 0, 100, -1, 0, ab);
        do_readout(0, -1);

        // trigger with no samples written at all
        do_capture(0, 0, 0, -1, 0, ab);
        do_readout(0, -1);

        // randomized captures
        for (int t = 0; t < 8; t++) begin
            do_capture($urandom_range(50), $urandom_range(40), 20 + $urandom_range(80), -1, 0, ab);
            do_readout($urandom_range(3), -1);
        end

        // post-trigger count overwrites the entire history
        do_capture(5, DEPTH - 1, 100, -1, 0, ab);
        do_readout(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
Capture sequencer for the logic-analyser sample buffer built on one RAMB16_S9-style block RAM (2048 x 8, 1-cycle read latency).
- Capture: while armed, continuously writes incoming samples into the RAM as a ring buffer. On trigger, captures a programmable number of post-trigger samples, then stops.
- Readout: streams the captured window to the transmitter, oldest sample first, over a valid/ready handshake.
- Sits between the sampler/trigger logic and the serial transmitter.

Parameters:
- AW, 11, RAM address width; DEPTH = 2^AW.
- DW, 8, sample/RAM data width.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- arm  in  1  start capture (honoured only in IDLE)
- abort  in  1  return to IDLE from any state
- run  in  1  trigger (honoured only in ARMED)
- post_count  in  AW  number of samples to write after the trigger cycle
- sample_valid  in  1  sample_data valid this cycle
- sample_data  in  DW  sample value
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0
- out_data  out  DW  readout word
- out_valid  out  1  readout word available
- out_ready  in  1  transmitter accepts out_data
- armed  out  1  state is ARMED or POST
- reading  out  1  state is RD_ISSUE, RD_WAIT or RD_HOLD
- done  out  1  one-cycle pulse when the last word is accepted

Behaviour:
States: IDLE, ARMED, POST, RD_ISSUE, RD_WAIT, RD_HOLD.

Reset:
- state=IDLE, wr_ptr=0, fill=0, post_left=0, rd_ptr=0, rd_left=0.
- out_valid=0, out_data=0, done=0.
- mem_en, mem_we, armed and reading all 0.

IDLE:
- mem_en=0, mem_we=0.
- arm=1 -> ARMED; clears wr_ptr and fill (fill is AW+1 bits).
- run is ignored.

ARMED / POST write path (combinational from state and inputs):
- mem_we = mem_en = sample_valid; mem_addr = wr_ptr; mem_din = sample_data.
- On each written sample: wr_ptr increments modulo DEPTH; fill increments, saturating at DEPTH.

ARMED:
- run=1 -> POST with post_left = post_count.
- A sample written in the same cycle as run is the trigger sample. It counts as pre-trigger and does not decrement post_left.
- If post_count=0, go directly from ARMED to RD_ISSUE instead of POST.

POST:
- run is ignored.
- Each written sample decrements post_left. The write that makes post_left=0 -> RD_ISSUE next cycle.
- Cycles without sample_valid hold state.

Entering readout:
- rd_ptr = (fill==DEPTH) ? wr_ptr : 0.
- rd_left = fill, using the fill value after any write in the transition cycle.
- If fill=0, go to IDLE with a done pulse and emit no words.

Readout, one word per at least 3 cycles:
- RD_ISSUE: mem_en=1, mem_we=0, mem_addr=rd_ptr -> RD_WAIT.
- RD_WAIT: register mem_dout into out_data; set out_valid=1 -> RD_HOLD.
- RD_HOLD: out_valid=1 and out_data stays stable until out_ready=1.
- On acceptance: out_valid=0; rd_ptr increments modulo DEPTH; rd_left decrements.
  - If rd_left was 1: done=1 for one cycle -> IDLE.
  - Otherwise -> RD_ISSUE.
- Ordering is strictly oldest to newest.
- No RAM access occurs in RD_WAIT or RD_HOLD.

Boundary and override rules:
- arm is ignored outside IDLE.
- abort has priority over arm, run and out_ready. Next state is IDLE, with out_valid=0, mem_we=0, no done pulse; RAM contents are untouched.
- reset mid-operation behaves like abort and also clears all counters.
- post_count of DEPTH-1 or more overwrites the entire pre-trigger history. This is legal; fill stays at DEPTH.
- Input data is not buffered: sample_valid is ignored in the readout states and in IDLE.

Test Plan:
1. No wrap, handshake ready: arm; samples 0x00..0x09 on consecutive cycles; run with 0x04; post_count=5 -> 10 writes to addr 0..9; readout 0x00..0x09 in order; done pulse on the 10th acceptance; then IDLE.
2. Wrap: arm; 3000 samples with data=i[7:0]; run on i=2999; post_count=0 -> 2048 words, first 0xB8 (i=952), incrementing mod 256; last 0xB7; first read address = 952 mod 2048 = 952.
3. Backpressure: during readout hold out_ready=0 for 5 cycles -> out_valid stays 1; out_data unchanged; mem_en=0; no pointer advance. Release -> the next word follows in exactly 3 cycles.
4. Abort in POST after 3 of 8 post samples -> next cycle: IDLE, armed=0, mem_we=0, out_valid never asserts, no done. A subsequent arm restarts with wr_ptr=0.
5. Ignored inputs:
   - run in IDLE -> no state change.
   - arm during RD_HOLD -> readout continues unchanged.
   - sample_valid during readout -> mem_we stays 0.
6. Reset asserted in RD_HOLD -> next cycle: all outputs 0, state IDLE. An arm/run sequence with 2 samples then reads back exactly those 2.
